// File: rtl/uop_pkg.sv
// uop_pkg
//   Shared types and sizing for the decoder -> instruction queue -> ROB path.
//   INSTR_Q_DEPTH / INSTR_Q_WIDTH : default queue depth and per-cycle lane count
//   uop_lane_cnt_t                : lane-count type shared with decoder and ROB
//   uop_insn                      : packed micro-op carried through the queue
package uop_pkg;

  localparam int INSTR_Q_DEPTH = 32;
  localparam int INSTR_Q_WIDTH = 4;

  typedef logic [$clog2(INSTR_Q_WIDTH+1)-1:0] uop_lane_cnt_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_ORR   = 4'd4,
    OP_LOAD  = 4'd5,
    OP_STORE = 4'd6,
    OP_BR    = 4'd7
  } uop_op_e;

  // tx_begin/tx_end delimit an atomic allocation group; a lone uop has both set.
  typedef struct packed {
    uop_op_e    op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       tx_begin;
    logic       tx_end;
  } uop_insn;

endpackage

// File: rtl/uop_tx_boundary.sv
// uop_tx_boundary
//   Finds how many head-of-queue uops form complete transactions.
//   i_tx_end : tx_end bits of the WIDTH entries at the queue head (lane 0 oldest)
//   i_occ    : current queue occupancy; lanes at or beyond it are not valid
//   o_avail  : index+1 of the last valid lane with tx_end set, 0 if none
module uop_tx_boundary
  import uop_pkg::*;
#(
  parameter int WIDTH = INSTR_Q_WIDTH,
  parameter int OCC_W = 6
) (
  input  logic [WIDTH-1:0]           i_tx_end,
  input  logic [OCC_W-1:0]           i_occ,
  output logic [$clog2(WIDTH+1)-1:0] o_avail
);

  localparam int CW = $clog2(WIDTH+1);

  // Later lanes overwrite earlier ones, leaving the youngest closed boundary.
  always_comb begin
    o_avail = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_avail = ((OCC_W'(i) < i_occ) && i_tx_end[i]) ? CW'(i + 1) : o_avail;
    end
  end

endmodule

// File: rtl/uop_instr_queue.sv
// uop_instr_queue
//   Circular buffer between decoder and ROB/dispatch. Accepts up to WIDTH uops per
//   cycle and exposes up to WIDTH per cycle, never showing a partial transaction.
//   clk_in / rst_N_in : clock, synchronous active-low reset
//   flush_in          : drop all contents; wins over enqueue and dequeue
//   enq_cnt_in/enq_uop_in/enq_rdy_out : decoder side (rdy = room for WIDTH uops)
//   deq_avail_out/deq_uop_out/deq_take_in : dispatch side (take clamped to avail)
//   occ_out           : occupancy
//   Optional macro UOP_INSTR_Q_STATS_EN adds hwm_out (peak occupancy since reset,
//   kept across flush) and stall_cnt_out (saturating count of refused offers).
module uop_instr_queue
  import uop_pkg::*;
#(
  parameter int DEPTH = INSTR_Q_DEPTH,
  parameter int WIDTH = INSTR_Q_WIDTH
) (
  input  logic                         clk_in,
  input  logic                         rst_N_in,
  input  logic                         flush_in,
  input  logic [$clog2(WIDTH+1)-1:0]   enq_cnt_in,
  input  uop_insn [WIDTH-1:0]          enq_uop_in,
  output logic                         enq_rdy_out,
  output logic [$clog2(WIDTH+1)-1:0]   deq_avail_out,
  output uop_insn [WIDTH-1:0]          deq_uop_out,
  input  logic [$clog2(WIDTH+1)-1:0]   deq_take_in,
  output logic [$clog2(DEPTH+1)-1:0]   occ_out
`ifdef UOP_INSTR_Q_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   hwm_out,
  output logic [31:0]                  stall_cnt_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = $clog2(WIDTH+1);

  uop_insn          r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [OW-1:0]    r_occ;
  logic             r_enq_rdy;

  uop_insn [WIDTH-1:0] w_head_win;
  logic [WIDTH-1:0] w_tx_end;
  logic [CW-1:0]    w_avail;
  logic [CW-1:0]    w_enq_n;
  logic [CW-1:0]    w_take_n;
  logic [OW-1:0]    w_occ_next;

  // Head window read straight from storage; only registered state feeds it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_head_win[i] = r_mem[r_head + PW'(i)];
      w_tx_end[i]   = w_head_win[i].tx_end;
    end
  end

  uop_tx_boundary #(
    .WIDTH (WIDTH),
    .OCC_W (OW)
  ) u_tx_boundary (
    .i_tx_end (w_tx_end),
    .i_occ    (r_occ),
    .o_avail  (w_avail)
  );

  // Accepted enqueue/dequeue counts; offers while not ready are dropped.
  always_comb begin
    w_enq_n  = '0;
    w_take_n = '0;
    if (rst_N_in && !flush_in) begin
      if (r_enq_rdy) begin
        w_enq_n = (enq_cnt_in > CW'(WIDTH)) ? CW'(WIDTH) : enq_cnt_in;
      end else begin
        w_enq_n = '0;
      end
      w_take_n = (deq_take_in > w_avail) ? w_avail : deq_take_in;
    end else begin
      w_enq_n  = '0;
      w_take_n = '0;
    end
    w_occ_next = r_occ + OW'(w_enq_n) - OW'(w_take_n);
  end

  // Pointer, occupancy and ready state; ready looks at next-cycle occupancy.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_occ     <= '0;
      r_enq_rdy <= 1'b1;
    end else if (flush_in) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_occ     <= '0;
      r_enq_rdy <= 1'b1;
    end else begin
      r_head    <= r_head + PW'(w_take_n);
      r_tail    <= r_tail + PW'(w_enq_n);
      r_occ     <= w_occ_next;
      r_enq_rdy <= (w_occ_next <= OW'(DEPTH - WIDTH));
    end
  end

  // Storage write; w_enq_n is already zero under reset, flush or not-ready.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) < w_enq_n) begin
        r_mem[r_tail + PW'(i)] <= enq_uop_in[i];
      end
    end
  end

  assign enq_rdy_out   = r_enq_rdy;
  assign deq_avail_out = w_avail;
  assign deq_uop_out   = w_head_win;
  assign occ_out       = r_occ;

`ifdef UOP_INSTR_Q_STATS_EN
  logic [OW-1:0] r_hwm;
  logic [31:0]   r_stall_cnt;

  // Peak occupancy survives flush; stall counter saturates instead of wrapping.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_hwm       <= '0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (!flush_in && (w_occ_next > r_hwm)) begin
        r_hwm <= w_occ_next;
      end
      if ((enq_cnt_in != '0) && !r_enq_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign hwm_out       = r_hwm;
  assign stall_cnt_out = r_stall_cnt;
`endif

endmodule
